col_out_collector: RTL
======================

COL_OUT_COLLECTOR -- requirements
Module: col_out_collector

Interface
REQ-001 SHALL have parameter COL, default 3: number of array columns/lanes.
REQ-002 SHALL have parameter W_DATA, default 8: bits per lane result.
REQ-003 SHALL have parameter DEPTH, default 4: row-buffer entries (power of two, >=2).
REQ-004 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_data_valid  input  COL  per-lane valid; bit i qualifies lane i.
REQ-007 SHALL have port i_data  input  W_DATA*COL  lane i at bits [W_DATA*(COL-i)-1 -: W_DATA] (lane 0 in MSBs).
REQ-008 SHALL have port o_row_data  output  W_DATA*COL  deskewed row, same lane packing as i_data.
REQ-009 SHALL have port o_row_valid  output  1  head row complete and presented.
REQ-010 SHALL have port i_row_ready  input  1  downstream accepts row.
REQ-011 SHALL have port i_clr_ovf  input  1  synchronous clear of o_overflow.
REQ-012 SHALL have port o_overflow  output  1  sticky: a lane write was dropped.
REQ-013 SHALL have port o_busy  output  1  any buffer entry holds any lane data.

Function
REQ-014 SHALL keep per-lane write pointer wp[i] (log2 DEPTH bits) and one shared read pointer rp.
REQ-015 SHALL keep per-entry lane-filled bitmap fill[e][COL-1:0] and per-entry data storage.
REQ-016 Lane write: i_data_valid[i]=1 and fill[wp[i]][i]=0 -> store lane data, set bit, wp[i]+1 mod DEPTH.
REQ-017 Lane write to entry whose bit is already set SHALL be dropped, wp[i] unchanged, o_overflow set next cycle.
REQ-018 Exception: write targeting entry rp in the same cycle that entry is popped SHALL be accepted (pop frees it first).
REQ-019 Lanes SHALL be independent; any skew between lanes up to DEPTH-1 rows is absorbed without loss.
REQ-020 o_row_valid SHALL equal registered &fill[rp]; o_row_data SHALL be entry rp contents (no comb path from i_data).
REQ-021 Latency: last lane of a row written at edge t -> o_row_valid high after edge t (one cycle).
REQ-022 Pop: o_row_valid & i_row_ready at edge -> clear fill[rp], rp+1 mod DEPTH; back-to-back pops every cycle SHALL be supported.
REQ-023 o_row_valid with i_row_ready=0 SHALL hold o_row_data stable until accepted.
REQ-024 i_row_ready while o_row_valid=0 SHALL have no effect.
REQ-025 Pointers SHALL wrap DEPTH-1 -> 0 without gap.
REQ-026 o_overflow SHALL stay set until i_clr_ovf; simultaneous clear and new drop -> o_overflow=1.
REQ-027 o_busy SHALL be OR of all fill bits, registered.

Reset
REQ-028 i_rst_n low SHALL immediately clear all fill bits, wp[], rp, o_overflow; o_row_valid=0, o_busy=0, o_row_data=0.
REQ-029 Reset mid-row SHALL discard partial rows; first post-reset lane writes land in entry 0.
REQ-030 Data storage other than o_row_data path need not be reset.

Verification
REQ-031 COL=3, ready=1; lanes 0,1,2 valid at cycles 0,1,2 with 0x11,0x22,0x33 -> o_row_valid at cycle 3, o_row_data=0x112233, one cycle.
REQ-032 All lanes valid together 6 cycles, values k*0x010101 (k=1..6), ready=1 -> six rows in order, wrap past DEPTH, o_overflow=0.
REQ-033 ready=0, lane 0 pushes 5 values, lanes 1,2 push 4 -> 4th row complete, lane 0's 5th dropped, o_overflow=1; ready=1 drains 4 rows, o_busy=0 after.
REQ-034 Buffer full, ready=1, lane 0 writes into rp entry same cycle it pops -> write accepted, o_overflow stays 0.
REQ-035 Assert i_rst_n=0 with 2 partial rows -> o_busy, o_row_valid, o_overflow 0 asynchronously; next full row appears from entry 0.
REQ-036 o_overflow=1, i_clr_ovf=1 with simultaneous drop -> stays 1; i_clr_ovf=1 alone -> 0 next cycle.

Source files
------------

// File: rtl/col_out_collector.sv
// Column output collector: absorbs per-lane skew from an array's columns and
// reassembles complete rows in a small per-lane-indexed buffer.
module col_out_collector #(
  parameter int COL    = 3,
  parameter int W_DATA = 8,
  parameter int DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [COL-1:0]        i_data_valid,
  input  logic [W_DATA*COL-1:0] i_data,
  output logic [W_DATA*COL-1:0] o_row_data,
  output logic                  o_row_valid,
  input  logic                  i_row_ready,
  input  logic                  i_clr_ovf,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;

  ptr_t                  wp_q [COL];
  ptr_t                  wp_d [COL];
  ptr_t                  rp_q, rp_d;
  logic [COL-1:0]        fill_q [DEPTH];
  logic [COL-1:0]        fill_d [DEPTH];
  logic [W_DATA-1:0]     mem_q [DEPTH][COL];
  logic [W_DATA-1:0]     lane_in [COL];
  logic [COL-1:0]        accept;
  logic                  drop_any;
  logic                  pop;
  logic                  row_valid_q, row_valid_d;
  logic [W_DATA*COL-1:0] row_data_q, row_data_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;

  always_comb begin
    for (int i = 0; i < COL; i++) begin
      lane_in[i] = i_data[W_DATA*(COL-i)-1 -: W_DATA];
    end
  end

  // Pop frees entry rp before lane writes are evaluated, so a lane wrapping
  // onto the head entry in the popping cycle is accepted rather than dropped.
  always_comb begin
    pop      = row_valid_q & i_row_ready;
    rp_d     = pop ? rp_q + ptr_t'(1) : rp_q;
    accept   = '0;
    drop_any = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      fill_d[e] = fill_q[e];
    end
    if (pop) begin
      fill_d[rp_q] = '0;
    end
    for (int i = 0; i < COL; i++) begin
      wp_d[i] = wp_q[i];
      if (i_data_valid[i]) begin
        if (!fill_q[wp_q[i]][i] || (pop && (wp_q[i] == rp_q))) begin
          accept[i]            = 1'b1;
          fill_d[wp_q[i]][i]   = 1'b1;
          wp_d[i]              = wp_q[i] + ptr_t'(1);
        end else begin
          drop_any = 1'b1;
        end
      end
    end
    busy_d = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      busy_d = busy_d | (|fill_d[e]);
    end
    row_valid_d = &fill_d[rp_d];
    // Head row is registered from next-state storage; no comb path to outputs.
    for (int i = 0; i < COL; i++) begin
      row_data_d[W_DATA*(COL-i)-1 -: W_DATA] =
        (accept[i] && (wp_q[i] == rp_d)) ? lane_in[i] : mem_q[rp_d][i];
    end
    ovf_d = drop_any | (ovf_q & ~i_clr_ovf);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < COL; i++) begin
        wp_q[i] <= '0;
      end
      for (int e = 0; e < DEPTH; e++) begin
        fill_q[e] <= '0;
      end
      rp_q        <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      for (int i = 0; i < COL; i++) begin
        wp_q[i] <= wp_d[i];
      end
      for (int e = 0; e < DEPTH; e++) begin
        fill_q[e] <= fill_d[e];
      end
      rp_q        <= rp_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < COL; i++) begin
      if (accept[i]) begin
        mem_q[wp_q[i]][i] <= lane_in[i];
      end
    end
  end

  assign o_row_data  = row_data_q;
  assign o_row_valid = row_valid_q;
  assign o_overflow  = ovf_q;
  assign o_busy      = busy_q;

endmodule
